// File: rtl/vga_mem_scheduler.sv
// vga_mem_scheduler: shares the framebuffer port between hblank line fetch and the GPU
// and sequences front/back buffer swaps with per-frame render starts.
module vga_mem_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int WPL      = 20,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              gpu_req,
  input  logic              gpu_we,
  input  logic [ADDR_W-1:0] gpu_addr,
  input  logic [DATA_W-1:0] gpu_wdata,
  output logic              gpu_gnt,
  output logic              gpu_rvalid,
  output logic [DATA_W-1:0] gpu_rdata,
  input  logic              gpu_frame_done,
  output logic              frame_start,
  output logic              front_buf,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [4:0]        lb_addr,
  output logic [DATA_W-1:0] lb_wdata
);
  if (WPL + 2 > H_TOTAL - H_ACTIVE || WPL > 32 || 2 * V_ACTIVE * WPL > (1 << ADDR_W)) begin : g_bad_params
    $error("vga_mem_scheduler: parameter set does not fit hblank, line buffer or address space");
  end
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] BUF_SZ = ADDR_W'(V_ACTIVE * WPL);
  state_t      state;
  logic [4:0]  i;
  logic [9:0]  line_q;
  logic        gpu_busy;
  logic        swap_pending;
  logic [9:0]  ny;
  logic [9:0]  line;
  logic [4:0]  idx;
  logic        fetch_start;
  logic        disp_rd;
  logic        vblank;
  logic        busy_next;
  logic        swap_next;
  always_comb begin
    ny          = (y == 10'(V_TOTAL - 1)) ? '0 : y + 10'd1;
    fetch_start = state == IDLE && x == 10'(H_ACTIVE) && ny < 10'(V_ACTIVE);
    disp_rd     = fetch_start || state == FETCH;
    idx         = fetch_start ? '0 : i;
    line        = fetch_start ? ny : line_q;
    gpu_gnt     = gpu_req && state == IDLE && !fetch_start;
    mem_en      = disp_rd || gpu_gnt;
    mem_we      = gpu_gnt && gpu_we;
    mem_addr    = disp_rd ? (front_buf ? BUF_SZ : '0) + ADDR_W'(line) * ADDR_W'(WPL) + ADDR_W'(idx)
                : gpu_gnt ? (front_buf ? '0 : BUF_SZ) + gpu_addr : '0;
    mem_wdata   = mem_we ? gpu_wdata : '0;
    gpu_rdata   = gpu_rvalid ? mem_rdata : '0;
    lb_wdata    = lb_we ? mem_rdata : '0;
    vblank      = x == 10'd0 && y == 10'(V_ACTIVE);
    busy_next   = gpu_busy && !gpu_frame_done;
    swap_next   = swap_pending || (gpu_busy && gpu_frame_done);
  end
  // lb_we / gpu_rvalid double as the return-path tags, so reset drops in-flight reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      i            <= '0;
      line_q       <= '0;
      gpu_busy     <= 1'b0;
      swap_pending <= 1'b0;
      front_buf    <= 1'b0;
      frame_start  <= 1'b0;
      lb_we        <= 1'b0;
      lb_addr      <= '0;
      lb_bank      <= 1'b0;
      gpu_rvalid   <= 1'b0;
    end else begin
      lb_we      <= disp_rd;
      gpu_rvalid <= gpu_gnt && !gpu_we;
      if (disp_rd) begin
        lb_addr <= idx;
        lb_bank <= line[0];
      end
      case (state)
        IDLE: if (fetch_start) begin
          state  <= (WPL == 1) ? DRAIN : FETCH;
          i      <= 5'd1;
          line_q <= ny;
        end
        FETCH: begin
          i     <= i + 5'd1;
          state <= (i == 5'(WPL - 1)) ? DRAIN : FETCH;
        end
        default: state <= IDLE;
      endcase
      frame_start <= vblank && !busy_next;
      if (vblank) begin
        front_buf    <= front_buf ^ swap_next;
        swap_pending <= 1'b0;
        gpu_busy     <= 1'b1;
      end else begin
        swap_pending <= swap_next;
        gpu_busy     <= busy_next;
      end
    end
  end
endmodule

// File: tb/tb_vga_mem_scheduler.sv
// tb_vga_mem_scheduler: directed vectors plus hand sequences for fetch, GPU arbitration,
// buffer swapping and mid-fetch reset; x/y are driven directly instead of a timing generator.
module tb_vga_mem_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        gpu_req = 1'b0;
  logic        gpu_we = 1'b0;
  logic [15:0] gpu_addr = '0;
  logic [31:0] gpu_wdata = '0;
  logic        gpu_frame_done = 1'b0;
  logic        gpu_gnt, gpu_rvalid, frame_start, front_buf;
  logic [31:0] gpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        lb_we, lb_bank;
  logic [4:0]  lb_addr;
  logic [31:0] lb_wdata;
  int passed = 0;
  int total = 0;

  vga_mem_scheduler dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
    .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .gpu_frame_done(gpu_frame_done), .frame_start(frame_start), .front_buf(front_buf),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_bank(lb_bank), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata)
  );

  always #20 clk = ~clk;

  // RAM model: each word reads back as C0DE followed by its own address
  always @(posedge clk) mem_rdata <= (mem_en && !mem_we) ? {16'hC0DE, mem_addr} : 32'h0;

  typedef struct {
    int   x;
    int   y;
    logic req;
    logic we;
    int   ga;
    logic done;
    logic e_gnt;
    logic e_en;
    logic e_we;
    int   e_addr;
    logic e_rv;
    logic e_fs;
    logic e_fb;
    logic e_lbwe;
  } vec_t;
  vec_t v[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int xx, input int yy, input logic req, input logic we,
                       input int ga, input logic done, input logic [31:0] wd);
    @(posedge clk);
    #1;
    x = 10'(xx);
    y = 10'(yy);
    gpu_req = req;
    gpu_we = we;
    gpu_addr = 16'(ga);
    gpu_frame_done = done;
    gpu_wdata = wd;
    @(negedge clk);
  endtask

  task automatic apply(input int n);
    logic [31:0] wd;
    wd = 32'h1234_0000 + 32'(n);
    drive(v[n].x, v[n].y, v[n].req, v[n].we, v[n].ga, v[n].done, wd);
    chk($sformatf("v%0d gnt", n), gpu_gnt, v[n].e_gnt);
    chk($sformatf("v%0d mem_en", n), mem_en, v[n].e_en);
    chk($sformatf("v%0d mem_we", n), mem_we, v[n].e_we);
    if (v[n].e_en) chk($sformatf("v%0d mem_addr", n), mem_addr, 128'(v[n].e_addr));
    if (v[n].e_we) chk($sformatf("v%0d mem_wdata", n), mem_wdata, wd);
    chk($sformatf("v%0d rvalid", n), gpu_rvalid, v[n].e_rv);
    chk($sformatf("v%0d frame_start", n), frame_start, v[n].e_fs);
    chk($sformatf("v%0d front_buf", n), front_buf, v[n].e_fb);
    chk($sformatf("v%0d lb_we", n), lb_we, v[n].e_lbwe);
  endtask

  // Drives x=640..660 on line yy and checks reads, line-buffer writes and the blocked GPU
  task automatic fetch_line(input int yy, input int base, input logic bank, input logic req,
                            input logic we, input int ga, input logic rv0, input logic [31:0] rd0);
    for (int k = 0; k <= 20; k++) begin
      drive(640 + k, yy, req, we, ga, 1'b0, 32'h0);
      chk($sformatf("fetch y%0d k%0d gnt", yy, k), gpu_gnt, 1'b0);
      chk($sformatf("fetch y%0d k%0d mem_en", yy, k), mem_en, k < 20);
      if (k < 20) begin
        chk($sformatf("fetch y%0d k%0d mem_we", yy, k), mem_we, 1'b0);
        chk($sformatf("fetch y%0d k%0d mem_addr", yy, k), mem_addr, 128'(base + k));
      end
      chk($sformatf("fetch y%0d k%0d lb_we", yy, k), lb_we, k > 0);
      if (k > 0) begin
        chk($sformatf("fetch y%0d k%0d lb_addr", yy, k), lb_addr, 128'(k - 1));
        chk($sformatf("fetch y%0d k%0d lb_bank", yy, k), lb_bank, bank);
        chk($sformatf("fetch y%0d k%0d lb_wdata", yy, k), lb_wdata, {16'hC0DE, 16'(base + k - 1)});
      end
      if (k == 0) begin
        chk($sformatf("fetch y%0d rvalid", yy), gpu_rvalid, rv0);
        if (rv0) chk($sformatf("fetch y%0d rdata", yy), gpu_rdata, rd0);
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " outs a"}, {mem_en, mem_we, mem_addr, mem_wdata, gpu_gnt, gpu_rvalid, gpu_rdata}, '0);
    chk({name, " outs b"}, {frame_start, front_buf, lb_we, lb_bank, lb_addr, lb_wdata}, '0);
  endtask

  initial begin
    //           x    y  req we ga dn  gnt en we addr  rv fs fb lbwe
    v[0]  = '{639,  10, 1, 0, 7, 0,  1, 1, 0, 9607, 0, 0, 0, 0};
    v[1]  = '{661,  10, 1, 0, 3, 0,  1, 1, 0, 9603, 0, 0, 0, 0};
    v[2]  = '{662,  10, 0, 0, 0, 0,  0, 0, 0, 0,    1, 0, 0, 0};
    v[3]  = '{0,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0};
    v[4]  = '{1,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 1, 0, 0};
    v[5]  = '{2,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0};
    v[6]  = '{5,   100, 0, 0, 0, 1,  0, 0, 0, 0,    0, 0, 0, 0};
    v[7]  = '{0,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 0, 0};
    v[8]  = '{1,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 1, 1, 0};
    v[9]  = '{700, 200, 1, 1, 4, 0,  1, 1, 1, 4,    0, 0, 1, 0};
    v[10] = '{0,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 1, 0};
    v[11] = '{1,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 0, 1, 0};
    v[12] = '{0,   480, 0, 0, 0, 1,  0, 0, 0, 0,    0, 0, 1, 0};
    v[13] = '{1,   480, 0, 0, 0, 0,  0, 0, 0, 0,    0, 1, 0, 0};
    v[14] = '{2,   480, 1, 0, 1, 0,  1, 1, 0, 9601, 0, 0, 0, 0};
    v[15] = '{3,   480, 0, 0, 0, 0,  0, 0, 0, 0,    1, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk_all_zero("in reset");
    reset = 1'b0;

    // line-0 fetch at end of frame with a GPU write held across it
    fetch_line(524, 0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 32'h0);
    drive(661, 524, 1'b1, 1'b1, 5, 1'b0, 32'hCAFE_F00D);
    chk("post-drain gnt", gpu_gnt, 1'b1);
    chk("post-drain mem_we", mem_we, 1'b1);
    chk("post-drain mem_addr", mem_addr, 128'd9605);
    chk("post-drain mem_wdata", mem_wdata, 32'hCAFE_F00D);
    drive(662, 524, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    chk("write no rvalid", gpu_rvalid, 1'b0);
    chk("idle mem_en", mem_en, 1'b0);

    // GPU read granted just before the fetch window returns alongside the first fetch read
    apply(0);
    fetch_line(10, 220, 1'b1, 1'b1, 1'b0, 3, 1'b1, {16'hC0DE, 16'd9607});
    for (int n = 1; n <= 2; n++) apply(n);
    chk("late read rdata", gpu_rdata, {16'hC0DE, 16'd9603});

    // first vblank start, frame done, swap, back buffer becomes 0
    for (int n = 3; n <= 9; n++) apply(n);
    fetch_line(524, 9600, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);

    // overrun vblank, then frame_done coinciding with vblank start
    for (int n = 10; n <= 15; n++) apply(n);

    // asynchronous reset at fetch word 7 of line 31
    for (int k = 0; k <= 7; k++) begin
      drive(640 + k, 30, 1'b0, 1'b0, 0, 1'b0, 32'h0);
      chk($sformatf("pre-reset k%0d mem_addr", k), mem_addr, 128'(620 + k));
    end
    reset = 1'b1;
    #1;
    chk_all_zero("mid-fetch reset");
    drive(648, 30, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    drive(649, 30, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    reset = 1'b0;
    for (int k = 10; k <= 21; k++) begin
      drive(640 + k, 30, 1'b0, 1'b0, 0, 1'b0, 32'h0);
      chk($sformatf("post-reset k%0d lb_we", k), lb_we, 1'b0);
      chk($sformatf("post-reset k%0d rvalid", k), gpu_rvalid, 1'b0);
      chk($sformatf("post-reset k%0d mem_en", k), mem_en, 1'b0);
    end
    fetch_line(31, 640, 1'b0, 1'b0, 1'b0, 0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/vga_mem_scheduler.md
Name: vga_mem_scheduler

Overview:
- Owns the single-port framebuffer memory and shares it between two requesters: display line fetch and the GPU rasterizer.
- Display fetch has priority. During each horizontal blank it copies the next visible line from the front buffer into a ping-pong line buffer. The GPU uses the port at all other times.
- Also sequences double buffering: front/back swap at vblank start and the per-frame render start pulse to the GPU.
- Sits between the 640x480 timing generator (x/y counters in) and the framebuffer RAM, line buffer and GPU core.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_TOTAL, 800, pixel clocks per line
V_ACTIVE, 480, visible lines
V_TOTAL, 525, lines per frame
WPL, 20, memory words per line; must satisfy WPL+2 <= H_TOTAL-H_ACTIVE
ADDR_W, 16, memory address width; must hold 2*V_ACTIVE*WPL
DATA_W, 32, memory word width

Ports:
clk  in  1  pixel clock (25 MHz)
reset  in  1  asynchronous, active-high
x  in  10  horizontal counter from timing generator
y  in  10  vertical counter from timing generator
gpu_req  in  1  GPU memory request; held until granted
gpu_we  in  1  1 = write, 0 = read
gpu_addr  in  ADDR_W  word offset within back buffer
gpu_wdata  in  DATA_W  write data
gpu_gnt  out  1  request accepted this cycle
gpu_rvalid  out  1  GPU read data valid on gpu_rdata
gpu_rdata  out  DATA_W  registered read data
gpu_frame_done  in  1  one-cycle pulse: back buffer fully rendered
frame_start  out  1  one-cycle pulse: GPU may begin rendering into back buffer
front_buf  out  1  buffer currently displayed
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_en && !mem_we
lb_we  out  1  line buffer write strobe
lb_bank  out  1  line buffer half, equals ny[0]
lb_addr  out  5  word index within line (0..WPL-1)
lb_wdata  out  DATA_W  line buffer write data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, gpu_busy=0, swap_pending=0, front_buf=0.
- Buffer bases:
  - buf_base(b) = b*V_ACTIVE*WPL.
  - Display reads use front_buf.
  - GPU accesses use ~front_buf: mem_addr = buf_base(~front_buf) + gpu_addr.
- Next line: ny = (y==V_TOTAL-1) ? 0 : y+1.
- FSM states are IDLE, FETCH and DRAIN.
- IDLE:
  - Enter FETCH when x==H_ACTIVE and ny < V_ACTIVE, with i=0. This includes line 524 for line 0.
  - Otherwise the port is free for the GPU.
- FETCH:
  - One read per cycle: mem_en=1, mem_we=0, mem_addr = buf_base(front_buf) + ny*WPL + i. ny is latched on entry.
  - i increments each cycle. After i==WPL-1, go to DRAIN.
- DRAIN: one cycle, then return to IDLE.
- Fetch is only entered at x==H_ACTIVE exactly. There is no late start after a missed window.
- GPU grant:
  - gpu_gnt = gpu_req && (state==IDLE) && !(fetch-start condition this cycle). It is combinational.
  - On grant, mem_* is driven from gpu_* in the same cycle.
  - If the fetch-start condition and gpu_req coincide, fetch wins and the GPU keeps waiting.
  - gpu_gnt is 0 throughout FETCH and DRAIN.
- Read return routing:
  - A 1-bit tag, registered at issue, steers mem_rdata on the following cycle.
  - Display reads produce lb_we=1, lb_addr = i registered at issue, lb_bank = ny[0], lb_wdata = mem_rdata.
  - GPU reads produce gpu_rvalid=1, gpu_rdata = mem_rdata.
  - A GPU read granted the cycle before FETCH returns correctly while the first fetch read is in flight.
  - GPU writes never raise gpu_rvalid.
- Frame sequencing:
  - gpu_frame_done while gpu_busy=1 clears gpu_busy and sets swap_pending.
  - gpu_frame_done while gpu_busy=0 is ignored.
  - At vblank start (x==0, y==V_ACTIVE), in order: apply any same-cycle gpu_frame_done; if swap_pending, toggle front_buf and clear swap_pending; then if gpu_busy==0, pulse frame_start on the next cycle and set gpu_busy=1.
  - After reset, the first vblank issues frame_start with no swap, so the GPU renders into buffer 1.
  - If the GPU overruns a frame, the old front buffer is redisplayed and no frame_start is issued.
- Asynchronous reset mid-fetch: FSM returns to IDLE, pending read tags are dropped, and there are no lb_we/gpu_rvalid pulses after reset. Operation resumes at the next fetch window.

Test Plan:
- Reset then run to y=524, x=640 -> 20 cycles of mem reads at addrs 0..19, lb_we at lb_addr 0..19 one cycle later with lb_bank=0; gpu_gnt=0 during cycles x=640..660.
- Hold gpu_req write at x=640 y=10 -> no grant until DRAIN ends (x=661), then gpu_gnt=1 with mem_addr = 9600+gpu_addr after the first frame_start.
- GPU read granted at x=639 y=10 -> gpu_rvalid at x=640 with RAM data; first lb_we at x=641 with data from addr 11*20.
- Reset, run to vblank -> frame_start pulse at (x=1, y=480), front_buf=0; gpu_frame_done at y=100 -> next vblank front_buf=1, frame_start pulse, line-0 fetch reads addr 9600..9619.
- No gpu_frame_done across a vblank -> front_buf unchanged, no frame_start; gpu_frame_done in the same cycle as vblank start -> swap and frame_start on that vblank.
- Assert reset at fetch word 7 -> all outputs 0 the same cycle, no further lb_we; after release, next line fetch is complete and correct.
